// File: rtl/acc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : acc_controller
//  Purpose  : Multi-cycle control sequencer for the EnDMe accumulator
//             datapath. Fetches 9-bit instructions, decodes them and drives
//             the accumulator source select / write strobe together with the
//             register-file, data-memory, ALU and PC controls.
//  Ports    :
//    clk, rst_n        clock, asynchronous active-low reset
//    i_start           leave IDLE and begin fetching
//    i_instr           9-bit instruction (opcode = [8:6])
//    i_instr_valid     instruction-memory acknowledge for o_fetch_req
//    i_mem_ready       data-memory acknowledge for o_mem_read/o_mem_write
//    i_acc_zero        accumulator == 0, consulted by BRZ
//    o_fetch_req       instruction fetch request
//    o_acc_data_ctrl   accumulator source: 00 imm, 01 reg, 10 mem, 11 alu
//    o_acc_write       accumulator write strobe (1-cycle pulse)
//    o_reg_write       register-file write strobe
//    o_mem_read/write  data-memory strobes, held for the handshake
//    o_operand         instr[5:0] of the current instruction
//    o_alu_op          instr[5:3] of the current instruction
//    o_pc_inc/o_pc_load PC controls (1-cycle pulses)
//    o_busy            high outside IDLE and HALT
//    o_halted/o_error  sticky status flags
//    o_instr_count     retired-instruction count, saturating
//  Revision : 1.0  initial release
// ============================================================================
module acc_controller #(
    parameter int MEM_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [8:0]  i_instr,
    input  logic        i_instr_valid,
    input  logic        i_mem_ready,
    input  logic        i_acc_zero,
    output logic        o_fetch_req,
    output logic [1:0]  o_acc_data_ctrl,
    output logic        o_acc_write,
    output logic        o_reg_write,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [5:0]  o_operand,
    output logic [2:0]  o_alu_op,
    output logic        o_pc_inc,
    output logic        o_pc_load,
    output logic        o_busy,
    output logic        o_halted,
    output logic        o_error,
    output logic [15:0] o_instr_count
);

    localparam logic [7:0] c_TIMEOUT = 8'(MEM_TIMEOUT);

    localparam logic [2:0] c_OP_LDI  = 3'd0;
    localparam logic [2:0] c_OP_LDR  = 3'd1;
    localparam logic [2:0] c_OP_LDM  = 3'd2;
    localparam logic [2:0] c_OP_ALU  = 3'd3;
    localparam logic [2:0] c_OP_STR  = 3'd4;
    localparam logic [2:0] c_OP_STM  = 3'd5;
    localparam logic [2:0] c_OP_BRZ  = 3'd6;
    localparam logic [2:0] c_OP_HALT = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [2:0]  r_opcode;      // opcode field of the instruction register
    logic [7:0]  r_wait;        // EXEC cycle number of a memory handshake
    logic [7:0]  w_wait_nxt;

    logic        r_fetch_req;
    logic [1:0]  r_acc_data_ctrl;
    logic        r_acc_write;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [5:0]  r_operand;
    logic [2:0]  r_alu_op;
    logic        r_pc_inc;
    logic        r_pc_load;
    logic        r_busy;
    logic        r_halted;
    logic        r_error;
    logic [15:0] r_instr_count;

    logic        w_ld_ir;
    logic        w_acc_write;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_pc_inc;
    logic        w_pc_load;
    logic        w_err_set;
    logic        w_retire;

    // Every output is registered, so the combinational block computes the
    // value each output must carry in the *next* state; the register stage
    // then presents it glitch-free for exactly the cycles of that state.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_ld_ir     = 1'b0;
        w_acc_write = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_pc_inc    = 1'b0;
        w_pc_load   = 1'b0;
        w_err_set   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                if (i_instr_valid) begin
                    w_ld_ir     = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end

            S_DECODE: begin
                if (r_opcode == c_OP_HALT) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_EXEC;
                    w_wait_nxt  = 8'd1;     // EXEC entry is cycle 1
                    case (r_opcode)
                        c_OP_LDI, c_OP_LDR, c_OP_ALU: begin
                            w_acc_write = 1'b1;
                            w_pc_inc    = 1'b1;
                        end
                        c_OP_STR: begin
                            w_reg_write = 1'b1;
                            w_pc_inc    = 1'b1;
                        end
                        c_OP_BRZ: begin
                            w_pc_load   = i_acc_zero;
                            w_pc_inc    = ~i_acc_zero;
                        end
                        c_OP_LDM: w_mem_read  = 1'b1;
                        c_OP_STM: w_mem_write = 1'b1;
                        default: ;
                    endcase
                end
            end

            S_EXEC: begin
                if ((r_opcode == c_OP_LDM) || (r_opcode == c_OP_STM)) begin
                    if (i_mem_ready) begin
                        // LDM writes the accumulator in WB; STM's retire
                        // pulse lands in the first cycle of the next FETCH.
                        w_pc_inc = 1'b1;
                        if (r_opcode == c_OP_LDM) begin
                            w_acc_write = 1'b1;
                            w_state_nxt = S_WB;
                        end else begin
                            w_state_nxt = S_FETCH;
                        end
                    end else if (r_wait >= c_TIMEOUT) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_HALT;
                    end else begin
                        w_wait_nxt  = r_wait + 8'd1;
                        w_mem_read  = (r_opcode == c_OP_LDM);
                        w_mem_write = (r_opcode == c_OP_STM);
                    end
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end

            S_WB: begin
                w_state_nxt = S_FETCH;
            end

            S_HALT: begin
                w_state_nxt = S_HALT;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_retire = w_pc_inc | w_pc_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_opcode        <= 3'd0;
            r_wait          <= 8'd0;
            r_fetch_req     <= 1'b0;
            r_acc_data_ctrl <= 2'b00;
            r_acc_write     <= 1'b0;
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_operand       <= 6'd0;
            r_alu_op        <= 3'd0;
            r_pc_inc        <= 1'b0;
            r_pc_load       <= 1'b0;
            r_busy          <= 1'b0;
            r_halted        <= 1'b0;
            r_error         <= 1'b0;
            r_instr_count   <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait      <= w_wait_nxt;
            r_fetch_req <= (w_state_nxt == S_FETCH);
            r_acc_write <= w_acc_write;
            r_reg_write <= w_reg_write;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_pc_inc    <= w_pc_inc;
            r_pc_load   <= w_pc_load;
            r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_HALT);
            r_halted    <= (w_state_nxt == S_HALT);
            r_error     <= r_error | w_err_set;

            // Decode fields are captured on the fetch edge so they are
            // already valid throughout DECODE: the accumulator source select
            // is then stable a full cycle ahead of any acc_write.
            if (w_ld_ir) begin
                r_opcode  <= i_instr[8:6];
                r_operand <= i_instr[5:0];
                r_alu_op  <= i_instr[5:3];
                if (!i_instr[8]) begin
                    r_acc_data_ctrl <= i_instr[7:6];
                end
            end

            if (w_retire && (r_instr_count != 16'hFFFF)) begin
                r_instr_count <= r_instr_count + 16'd1;
            end
        end
    end

    assign o_fetch_req     = r_fetch_req;
    assign o_acc_data_ctrl = r_acc_data_ctrl;
    assign o_acc_write     = r_acc_write;
    assign o_reg_write     = r_reg_write;
    assign o_mem_read      = r_mem_read;
    assign o_mem_write     = r_mem_write;
    assign o_operand       = r_operand;
    assign o_alu_op        = r_alu_op;
    assign o_pc_inc        = r_pc_inc;
    assign o_pc_load       = r_pc_load;
    assign o_busy          = r_busy;
    assign o_halted        = r_halted;
    assign o_error         = r_error;
    assign o_instr_count   = r_instr_count;

endmodule
`default_nettype wire
